// File: rtl/avalon_regfile_pkg.sv
// Shared definitions for the Avalon-MM register file: FSM encodings,
// default bad-address read value and a constant log2 helper.
package avalon_regfile_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [31:0] BAD_ADDR_DEFAULT = 32'hDEAD_BEEF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_wait_fsm.sv
// Wait-state handshake for one Avalon-MM transfer; ack marks the single
// cycle in which the request is sampled and committed.
//   state   | meaning
//   IDLE    | no transfer in progress, waiting for read|write
//   WAIT    | counting WAIT_STATES stall cycles
//   ACK     | transfer accepted, waitrequest released for one cycle
module avalon_wait_fsm
  import avalon_regfile_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic iClk,
  input  logic nReset,
  input  logic req,
  output logic ack,
  output logic ack_next,
  output logic waitrequest
);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        // A request dropped mid-stall is abandoned without commit.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack         = (state_q == ST_ACK);
  assign ack_next    = (state_d == ST_ACK);
  assign waitrequest = req & (state_q != ST_ACK);

endmodule

// File: rtl/avalon_regfile.sv
// Parametrised Avalon-MM slave register file with per-lane byteenable,
// hardware-sourced read-only registers and per-register write strobes.
module avalon_regfile
  import avalon_regfile_pkg::*;
#(
  parameter int                            NUM_REGS      = 4,
  parameter int                            DATA_WIDTH    = 32,
  parameter int                            ADDR_WIDTH    = 11,
  parameter int                            WAIT_STATES   = 0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK      = '0,
  parameter logic [31:0]                    BAD_ADDR_DATA = BAD_ADDR_DEFAULT
) (
  input  logic                           iClk,
  input  logic                           nReset,
  input  logic [ADDR_WIDTH-1:0]          avs_address,
  input  logic [DATA_WIDTH/8-1:0]        avs_byteenable,
  input  logic                           avs_read,
  output logic [DATA_WIDTH-1:0]          avs_readdata,
  input  logic                           avs_write,
  input  logic [DATA_WIDTH-1:0]          avs_writedata,
  output logic                           avs_waitrequest,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] iHwRegs,
  output logic [NUM_REGS*DATA_WIDTH-1:0] oRegs,
  output logic [NUM_REGS-1:0]            oWrStrobe
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = clog2(LANES);
  localparam int IDX_W     = ADDR_WIDTH - LANE_BITS;

  logic ack, ack_next;

  avalon_wait_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .iClk       (iClk),
    .nReset     (nReset),
    .req        (avs_read | avs_write),
    .ack        (ack),
    .ack_next   (ack_next),
    .waitrequest(avs_waitrequest)
  );

  logic [IDX_W-1:0] idx;
  logic [31:0]      idx_ext;
  assign idx     = avs_address[ADDR_WIDTH-1:LANE_BITS];
  assign idx_ext = 32'(idx);

  if (LANE_BITS > 0) begin : g_lane_bits
    logic unused_lane_addr;
    assign unused_lane_addr = ^avs_address[LANE_BITS-1:0];
  end

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_hit;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr_hit[i]    = ack & avs_write & (idx_ext == i) & ~RO_MASK[i];
    assign oWrStrobe[i] = wr_hit[i] & (|avs_byteenable);

    always_ff @(posedge iClk) begin
      if (!nReset) begin
        regs_q[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (wr_hit[i]) begin
        for (int b = 0; b < LANES; b++) begin
          if (avs_byteenable[b]) regs_q[i][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end

    // RO registers keep unused storage at reset value; the view is hardware.
    assign oRegs[i*DATA_WIDTH +: DATA_WIDTH] =
      RO_MASK[i] ? iHwRegs[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
  end

  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    rd_val = DATA_WIDTH'(BAD_ADDR_DATA);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_ext == i) rd_val = oRegs[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Loaded on entry to ACK and cleared afterwards, so it is 0 outside ACK.
  always_ff @(posedge iClk) begin
    if (!nReset) begin
      avs_readdata <= '0;
    end else if (ack_next & avs_read & ~avs_write) begin
      avs_readdata <= rd_val;
    end else begin
      avs_readdata <= '0;
    end
  end

endmodule

// File: tb/tb_avalon_regfile.sv
// Directed bench for avalon_regfile: a default instance and one with
// wait states, a read-only register and a non-zero reset value.
module tb_avalon_regfile;
  import avalon_regfile_pkg::*;

  logic         clk = 1'b0;
  logic         nReset;
  logic [10:0]  addr;
  logic [3:0]   ben;
  logic [31:0]  wdata;
  logic         rd0, wr0, rd1, wr1;
  logic [31:0]  rdata0, rdata1;
  logic         wreq0, wreq1;
  logic [127:0] regs0, regs1;
  logic [3:0]   strb0, strb1;
  logic [127:0] hw0, hw1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_regfile dut0 (
    .iClk(clk), .nReset(nReset), .avs_address(addr), .avs_byteenable(ben),
    .avs_read(rd0), .avs_readdata(rdata0), .avs_write(wr0), .avs_writedata(wdata),
    .avs_waitrequest(wreq0), .iHwRegs(hw0), .oRegs(regs0), .oWrStrobe(strb0)
  );

  avalon_regfile #(
    .WAIT_STATES(3),
    .RESET_VALUE(128'h0000_0000_0000_0000_5555_AAAA_0000_0000),
    .RO_MASK    (4'b1000)
  ) dut1 (
    .iClk(clk), .nReset(nReset), .avs_address(addr), .avs_byteenable(ben),
    .avs_read(rd1), .avs_readdata(rdata1), .avs_write(wr1), .avs_writedata(wdata),
    .avs_waitrequest(wreq1), .iHwRegs(hw1), .oRegs(regs1), .oWrStrobe(strb1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer; returns readdata and strobe seen in the ACK cycle
  // and the number of cycles waitrequest was high before it.
  task automatic xfer(input int d, input logic rd, input logic wr, input logic [10:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rdv, output logic [3:0] stb, output int n);
    addr = a; ben = be; wdata = wd;
    if (d == 0) begin rd0 = rd; wr0 = wr; end
    else        begin rd1 = rd; wr1 = wr; end
    n = 0; rdv = 'x; stb = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (((d == 0) ? wreq0 : wreq1) == 1'b0) begin
        rdv = (d == 0) ? rdata0 : rdata1;
        stb = (d == 0) ? strb0 : strb1;
        break;
      end
      n++;
    end
    @(posedge clk); #1;
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
  endtask

  logic [31:0] rv;
  logic [3:0]  sv;
  int          nw;
  logic [9:0]  pat;

  initial begin
    nReset = 0; addr = '0; ben = '0; wdata = '0;
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    hw0 = '0;
    hw1 = {32'hCAFE_F00D, 96'h0};
    repeat (3) @(posedge clk);
    #1 nReset = 1;
    @(posedge clk); #1;

    chk("rst_wreq0", wreq0, 1'b0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_strb0", strb0, 4'h0);
    chk("rst_regs0", regs0, 128'h0);
    chk("rst_regs1", regs1, {32'hCAFE_F00D, 96'h0000_0000_5555_AAAA_0000_0000});

    for (int r = 0; r < 4; r++) begin
      xfer(0, 1, 0, 11'(r * 4), 4'hF, 32'h0, rv, sv, nw);
      chk($sformatf("rd%0d_data", r), rv, 32'h0);
      chk($sformatf("rd%0d_wait", r), nw, 1);
    end

    xfer(0, 0, 1, 11'h004, 4'b0101, 32'h1122_3344, rv, sv, nw);
    chk("be_wait", nw, 1);
    chk("be_strobe", sv, 4'b0010);
    chk("be_strobe_after", strb0, 4'b0000);
    chk("be_oregs1", regs0[63:32], 32'h0022_0044);
    chk("rdata_idle", rdata0, 32'h0);
    xfer(0, 1, 0, 11'h004, 4'h0, 32'h0, rv, sv, nw);
    chk("be_readback", rv, 32'h0022_0044);

    xfer(0, 1, 0, 11'h040, 4'hF, 32'h0, rv, sv, nw);
    chk("bad_rd", rv, 32'hDEAD_BEEF);
    xfer(0, 0, 1, 11'h040, 4'hF, 32'h1234_5678, rv, sv, nw);
    chk("bad_wr_wait", nw, 1);
    chk("bad_wr_strobe", sv, 4'h0);
    chk("bad_wr_regs", regs0, {64'h0, 32'h0022_0044, 32'h0});

    xfer(0, 0, 1, 11'h000, 4'h0, 32'hFFFF_FFFF, rv, sv, nw);
    chk("be0_strobe", sv, 4'h0);
    chk("be0_reg0", regs0[31:0], 32'h0);

    xfer(0, 1, 1, 11'h008, 4'hF, 32'hA5A5_A5A5, rv, sv, nw);
    chk("rw_rdata", rv, 32'h0);
    chk("rw_strobe", sv, 4'b0100);
    chk("rw_reg2", regs0[95:64], 32'hA5A5_A5A5);

    xfer(1, 0, 1, 11'h000, 4'hF, 32'h1234_5678, rv, sv, nw);
    chk("ws_wait", nw, 4);
    chk("ws_strobe", sv, 4'b0001);
    chk("ws_reg0", regs1[31:0], 32'h1234_5678);

    addr = 11'h000; ben = 4'hF; wdata = 32'h0BAD_CAFE; wr1 = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pat[9-k] = wreq1;
    end
    @(posedge clk); #1 wr1 = 0;
    chk("b2b_pattern", pat, 10'b1111011110);
    chk("b2b_reg0", regs1[31:0], 32'h0BAD_CAFE);

    xfer(1, 0, 1, 11'h00C, 4'hF, 32'hFFFF_FFFF, rv, sv, nw);
    chk("ro_wr_strobe", sv, 4'h0);
    chk("ro_oregs3", regs1[127:96], 32'hCAFE_F00D);
    xfer(1, 1, 0, 11'h00C, 4'hF, 32'h0, rv, sv, nw);
    chk("ro_rd", rv, 32'hCAFE_F00D);
    chk("ro_rd_wait", nw, 4);

    addr = 11'h004; ben = 4'hF; wdata = 32'h0; wr1 = 1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 nReset = 0;
    @(posedge clk); #1;
    wr1 = 0; nReset = 1;
    chk("rst_mid_reg1", regs1[63:32], 32'h5555_AAAA);
    chk("rst_mid_state", dut1.u_fsm.state_q, ST_IDLE);
    chk("rst_mid_rdata", rdata1, 32'h0);
    chk("rst_mid_strobe", strb1, 4'h0);
    xfer(1, 1, 0, 11'h004, 4'hF, 32'h0, rv, sv, nw);
    chk("rst_mid_rd", rv, 32'h5555_AAAA);
    chk("rst_mid_rd_wait", nw, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
